// File: rtl/priority_arbiter_8.sv
// ---------------------------------------------------------------------------
// priority_arbiter_8
//
// Shares one downstream resource among 8 requesters. A winner is picked in
// IDLE, either by fixed priority (highest index wins) or by round-robin
// (search starts just below the previous owner and wraps). The owner keeps
// the grant until it releases, drops its request, or has held the grant for
// MAX_HOLD cycles. A one-cycle GAP always follows each grant, so there are
// at least two cycles with validOut=0 between consecutive owners.
//
// Ports
//   clk        : system clock, rising-edge active
//   resetN     : asynchronous active-low reset
//   reqIn      : level-sensitive request lines, bit i = requester i
//   rrEnable   : 1 = round-robin, 0 = fixed priority (looked at in IDLE only)
//   releaseIn  : owner is done (looked at in GRANT only)
//   grantOut   : one-hot grant, zero when nobody owns the resource
//   codeOut    : index of the current owner; keeps the last owner when idle
//   validOut   : 1 while a grant is active (equals |grantOut)
//   timeoutOut : one-cycle pulse when an ownership is cut off by MAX_HOLD
//
// All outputs come straight from flops; nothing on the inputs reaches an
// output without passing through a clock edge.
// ---------------------------------------------------------------------------
module priority_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 15  // legal range 1..255
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] reqIn,
  input  logic       rrEnable,
  input  logic       releaseIn,
  output logic [7:0] grantOut,
  output logic [2:0] codeOut,
  output logic       validOut,
  output logic       timeoutOut
);

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] code_q, code_d;      // doubles as the round-robin pointer
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_q, hold_d;      // grant cycles used by the current owner

  // Winner selection
  logic [2:0] fixed_win;
  logic [2:0] rr_win;
  logic [2:0] rr_idx;
  logic       rr_found;
  logic [2:0] win;

  // Grant-phase conditions
  logic       owner_req;
  logic       hold_at_max;
  logic       grant_exit;

  // -------------------------------------------------------------------------
  // Winner selection. Fixed mode scans upward so the last hit is the highest
  // set index. Round-robin walks code_q-1, code_q-2, ... and wraps; the 8th
  // step (k=8 truncates to 0) lands back on code_q itself, so the previous
  // owner is considered last.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    fixed_win = '0;
    rr_win    = '0;
    rr_idx    = '0;
    rr_found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (reqIn[i]) fixed_win = 3'(i);
    end
    for (int k = 1; k <= 8; k++) begin
      rr_idx = code_q - 3'(k);
      if (!rr_found && reqIn[rr_idx]) begin
        rr_win   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign win = rrEnable ? rr_win : fixed_win;

  assign owner_req   = reqIn[code_q];
  assign hold_at_max = (hold_q == MaxHold);
  assign grant_exit  = releaseIn || !owner_req || hold_at_max;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|reqIn) state_d = S_GRANT;
      S_GRANT: if (grant_exit) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values. timeoutOut defaults to 0 so it can only
  // ever be a single-cycle pulse.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_d   = grant_q;
    code_d    = code_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (|reqIn) begin
          grant_d = 8'b1 << win;
          code_d  = win;
          valid_d = 1'b1;
          hold_d  = 8'd1;
        end
      end
      S_GRANT: begin
        if (grant_exit) begin
          grant_d   = '0;
          valid_d   = 1'b0;
          // A release or request drop on the last allowed cycle counts as
          // a normal release, not a timeout.
          timeout_d = hold_at_max && !releaseIn && owner_req;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_GAP: begin
        grant_d = '0;
        valid_d = 1'b0;
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      grant_q   <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      grant_q   <= grant_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign grantOut   = grant_q;
  assign codeOut    = code_q;
  assign validOut   = valid_q;
  assign timeoutOut = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_priority_arbiter_8
//
// Directed bench for priority_arbiter_8 with MAX_HOLD=4. Each table record
// holds the inputs applied before a rising edge and the outputs expected
// just after it. The mid-cycle reset is driven by hand.
// ---------------------------------------------------------------------------
module tb_priority_arbiter_8;

  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] reqIn;
  logic       rrEnable;
  logic       releaseIn;
  logic [7:0] grantOut;
  logic [2:0] codeOut;
  logic       validOut;
  logic       timeoutOut;

  int checks = 0;
  int errors = 0;
  int vec_id = 0;

  typedef struct {
    logic [7:0] req;
    logic       rr;
    logic       rel;
    logic [7:0] grant;
    logic [2:0] code;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vq[$];

  priority_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .reqIn     (reqIn),
    .rrEnable  (rrEnable),
    .releaseIn (releaseIn),
    .grantOut  (grantOut),
    .codeOut   (codeOut),
    .validOut  (validOut),
    .timeoutOut(timeoutOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] req, input logic rr, input logic rel,
                     input logic [7:0] grant, input logic [2:0] code,
                     input logic valid, input logic tmo);
    vec_t v;
    v.req = req; v.rr = rr; v.rel = rel;
    v.grant = grant; v.code = code; v.valid = valid; v.tmo = tmo;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] g, input logic [2:0] c,
                               input logic v, input logic t);
    check({tag, " grant"},   32'(grantOut),   32'(g));
    check({tag, " code"},    32'(codeOut),    32'(c));
    check({tag, " valid"},   32'(validOut),   32'(v));
    check({tag, " timeout"}, 32'(timeoutOut), 32'(t));
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      reqIn     = vq[i].req;
      rrEnable  = vq[i].rr;
      releaseIn = vq[i].rel;
      tick();
      check_outputs($sformatf("v%0d", vec_id), vq[i].grant, vq[i].code, vq[i].valid, vq[i].tmo);
      vec_id++;
    end
    vq.delete();
  endtask

  task automatic do_reset(input string tag);
    resetN    = 1'b0;
    reqIn     = '0;
    rrEnable  = 1'b0;
    releaseIn = 1'b0;
    repeat (2) tick();
    check_outputs(tag, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rot [9];
    rot = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    // Reset asserted from time zero: outputs clear before any clock edge.
    resetN = 1'b0; reqIn = '0; rrEnable = 1'b0; releaseIn = 1'b0;
    #1;
    check_outputs("reset0", 8'h00, 3'd0, 1'b0, 1'b0);
    do_reset("reset1");

    // Fixed priority: 00010110 -> requester 4, twice with a gap between.
    add(8'h16, 0, 0, 8'h10, 3'd4, 1, 0);
    add(8'h16, 0, 1, 8'h00, 3'd4, 0, 0);  // GAP
    add(8'h16, 0, 0, 8'h00, 3'd4, 0, 0);  // IDLE
    add(8'h16, 0, 0, 8'h10, 3'd4, 1, 0);
    add(8'h16, 0, 1, 8'h00, 3'd4, 0, 0);
    add(8'h00, 0, 0, 8'h00, 3'd4, 0, 0);
    run_vecs();

    do_reset("reset2");

    // Round-robin rotation from reset: 7,6,...,0,7 with two idle cycles each.
    for (int i = 0; i < 9; i++) begin
      add(8'hFF, 1, 0, 8'(1) << rot[i], 3'(rot[i]), 1, 0);
      if (i < 8) begin
        add(8'hFF, 1, 1, 8'h00, 3'(rot[i]), 0, 0);
        add(8'hFF, 1, 0, 8'h00, 3'(rot[i]), 0, 0);
      end
    end

    // Round-robin skip: make 5 the last owner, then 01000001 -> 0, then 6.
    add(8'h20, 0, 1, 8'h00, 3'd7, 0, 0);
    add(8'h20, 0, 0, 8'h00, 3'd7, 0, 0);
    add(8'h20, 0, 0, 8'h20, 3'd5, 1, 0);
    add(8'h20, 0, 1, 8'h00, 3'd5, 0, 0);
    add(8'h41, 1, 0, 8'h00, 3'd5, 0, 0);
    add(8'h41, 1, 0, 8'h01, 3'd0, 1, 0);
    add(8'h41, 1, 1, 8'h00, 3'd0, 0, 0);
    add(8'h41, 1, 0, 8'h00, 3'd0, 0, 0);
    add(8'h41, 1, 0, 8'h40, 3'd6, 1, 0);
    add(8'h41, 1, 1, 8'h00, 3'd6, 0, 0);
    add(8'h00, 0, 0, 8'h00, 3'd6, 0, 0);

    // Timeout: four grant cycles, pulse with the grant drop, then re-grant.
    add(8'h04, 0, 0, 8'h04, 3'd2, 1, 0);
    add(8'h04, 0, 0, 8'h04, 3'd2, 1, 0);
    add(8'h04, 0, 0, 8'h04, 3'd2, 1, 0);
    add(8'h04, 0, 0, 8'h04, 3'd2, 1, 0);
    add(8'h04, 0, 0, 8'h00, 3'd2, 0, 1);
    add(8'h04, 0, 0, 8'h00, 3'd2, 0, 0);
    add(8'h04, 0, 0, 8'h04, 3'd2, 1, 0);

    // Owner drops its request in grant cycle 2: normal exit, no timeout.
    add(8'h04, 0, 0, 8'h04, 3'd2, 1, 0);
    add(8'h00, 0, 0, 8'h00, 3'd2, 0, 0);
    add(8'h00, 0, 0, 8'h00, 3'd2, 0, 0);
    add(8'h00, 0, 0, 8'h00, 3'd2, 0, 0);

    // Release on the fourth cycle: no timeout; requester 7 cannot preempt.
    add(8'h04, 0, 0, 8'h04, 3'd2, 1, 0);
    add(8'h84, 0, 0, 8'h04, 3'd2, 1, 0);
    add(8'h84, 0, 0, 8'h04, 3'd2, 1, 0);
    add(8'h84, 0, 0, 8'h04, 3'd2, 1, 0);
    add(8'h84, 0, 1, 8'h00, 3'd2, 0, 0);
    add(8'h00, 0, 0, 8'h00, 3'd2, 0, 0);
    run_vecs();

    // Asynchronous reset between edges while a grant is active.
    reqIn = 8'hFF; rrEnable = 1'b1; releaseIn = 1'b0;
    tick();
    check_outputs("rr_after_2", 8'h02, 3'd1, 1'b1, 1'b0);
    #3;
    resetN = 1'b0;
    #1;
    check_outputs("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    tick();
    check_outputs("post_rst", 8'h80, 3'd7, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_arbiter_8.md
# priority_arbiter_8

Sequential arbiter that shares one resource among 8 requesters, built around the 8-to-3 priority-encoding rule: highest index wins in fixed mode. It adds a round-robin mode, grant hold with release, a hold timeout, and a mandatory idle gap between grants. The arbiter sits in front of a shared datapath. Its 3-bit code output drives the datapath's source select, and the one-hot grant output acknowledges the requester.

## Interface
Parameters:
- MAX_HOLD, 15: maximum consecutive grant cycles per ownership, legal range 1..255.

Ports:
- clk, input, 1: system clock; all state changes occur on the rising edge.
- resetN, input, 1: asynchronous, active-low reset.
- reqIn, input, 8: request lines; bit i is requester i; level-sensitive.
- rrEnable, input, 1: 1 selects round-robin priority, 0 selects fixed priority; sampled only in IDLE.
- releaseIn, input, 1: current owner finished; sampled only in GRANT.
- grantOut, output, 8: one-hot grant, all-zero when no owner.
- codeOut, output, 3: binary index of the current owner; holds the last owner when validOut=0.
- validOut, output, 1: 1 while a grant is active; equals |grantOut.
- timeoutOut, output, 1: one-cycle pulse when an ownership is revoked by MAX_HOLD.

## Operation
- States: IDLE, GRANT, GAP. Encoding is free.
- Reset (asynchronous, resetN=0):
  - State goes to IDLE.
  - grantOut=0, codeOut=0, validOut=0, timeoutOut=0.
  - holdCount=0, lastCode=0.
- IDLE:
  - If reqIn==0, stay in IDLE.
  - Otherwise select winner w:
    - Fixed mode (rrEnable=0): w is the highest set index of reqIn.
    - Round-robin mode (rrEnable=1): search order is lastCode-1, lastCode-2, ..., wrapping mod 8, ending at lastCode. w is the first set bit in that order.
  - Next edge: state goes to GRANT, grantOut=1<<w, codeOut=w, validOut=1, lastCode=w, holdCount=1.
- GRANT, owner o:
  - Exit to GAP on the first edge where releaseIn=1, or reqIn[o]=0, or holdCount==MAX_HOLD.
  - Otherwise holdCount increments.
  - Requests from other requesters are ignored; there is no preemption.
- GAP:
  - Lasts exactly one cycle; grantOut=0 and validOut=0.
  - Always returns to IDLE.
- timeoutOut:
  - Set to 1 on the GRANT→GAP edge only if holdCount==MAX_HOLD and releaseIn=0 and reqIn[o]=1.
  - Cleared on the next edge.
  - When release or a request drop coincides with holdCount==MAX_HOLD, the exit is a normal release and timeoutOut stays 0.
- Round-robin after reset: lastCode=0 gives search order 7,6,...,0. The first arbitration after reset therefore matches fixed mode.
- holdCount is 8 bits wide; it never exceeds MAX_HOLD.
- X or Z on reqIn is not supported; the bench drives only 0 and 1.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request to grant:
  - A request sampled in IDLE at edge N shows grantOut at edge N.
  - The request is therefore visible 1 cycle after it was set up before edge N.
- Ownership length:
  - Minimum is 1 grant cycle: release is sampled high at the first GRANT edge.
  - Maximum is MAX_HOLD grant cycles.
- Re-grant turnaround: grant drop (GAP) → IDLE → new grant. That is a minimum of 2 cycles with validOut=0 between consecutive grants, even for the same requester.
- Reset asserted mid-grant: all outputs clear immediately, without waiting for clk. lastCode returns to 0.
- After resetN deasserts, the first edge evaluates IDLE normally.
- rrEnable changes during GRANT or GAP take effect at the next IDLE evaluation.

## Test plan
- Reset and fixed priority: reset, then drive rrEnable=0 and reqIn=8'b00010110.
  - Required: after 1 edge, grantOut=8'b00010000, codeOut=4, validOut=1.
  - Pulse releaseIn: GAP for 1 cycle, then the next grant goes to index 4 again (fixed priority, requester 4 still requesting).
- Round-robin rotation: rrEnable=1, reqIn=8'hFF held, releaseIn pulsed in each grant's first cycle.
  - Required grant codes in order: 7,6,5,4,3,2,1,0,7.
  - validOut=0 for exactly 2 cycles between consecutive grants.
- Round-robin skip: lastCode=5, reqIn=8'b01000001.
  - Required: grant to 0 (search order 4,3,2,1,0).
  - After release, grant to 6.
- Timeout: MAX_HOLD=4, reqIn=8'b00000100 held, releaseIn=0.
  - Required: grantOut=8'b00000100 for exactly 4 cycles.
  - timeoutOut=1 for 1 cycle together with grant drop, then requester 2 is re-granted after the gap.
- Request drop and coincidence:
  - Owner drops reqIn on grant cycle 2: grant ends, timeoutOut stays 0.
  - With MAX_HOLD=4, releaseIn=1 on cycle 4: timeoutOut stays 0.
- Asynchronous reset mid-grant: drive resetN low between clock edges while validOut=1.
  - Required: grantOut=0, codeOut=0, validOut=0 before the next clk edge.
  - After reset release with rrEnable=1 and reqIn=8'hFF: grant to 7.
